mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Shares one memory port between instruction fetch and data access.
//            Define ARB_RR_EN for round-robin conflicts; default is data-first.
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  // instruction port
  input  logic             instr_read,
  input  logic [WIDTH-1:0] instr_mem_address,
  output logic             instr_mem_resp,
  output logic [WIDTH-1:0] instr_mem_rdata,
  // data port
  input  logic             data_read,
  input  logic             data_write,
  input  logic [3:0]       data_mbe,
  input  logic [WIDTH-1:0] data_mem_address,
  input  logic [WIDTH-1:0] data_mem_wdata,
  output logic             data_mem_resp,
  output logic [WIDTH-1:0] data_mem_rdata,
  // shared memory port
  output logic             mem_read,
  output logic             mem_write,
  output logic [WIDTH-1:0] mem_address,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_mbe,
  input  logic             mem_resp,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam logic [1:0] c_idle    = 2'd0;
  localparam logic [1:0] c_serve_i = 2'd1;
  localparam logic [1:0] c_serve_d = 2'd2;
  localparam logic [1:0] c_resp    = 2'd3;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic [3:0]       r_mbe;
  logic             r_read;
  logic             r_write;
  logic [WIDTH-1:0] r_rdata;
  logic             r_resp_data;

  logic w_i_req;
  logic w_d_req;
  logic w_grant_d;
  logic w_serving;
  logic w_in_resp;

  assign w_i_req   = instr_read;
  assign w_d_req   = data_read | data_write;
  assign w_serving = (r_state == c_serve_i) || (r_state == c_serve_d);
  assign w_in_resp = (r_state == c_resp);

`ifdef ARB_RR_EN
  // Last-grant flag: 0 = instruction, so the first conflict goes to data.
  logic r_last_data;

  assign w_grant_d = w_d_req & (~w_i_req | ~r_last_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_data <= 1'b0;
    end else if (r_state == c_idle && (w_i_req || w_d_req)) begin
      r_last_data <= w_grant_d;
    end
  end
`else
  assign w_grant_d = w_d_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_idle;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_mbe       <= 4'h0;
      r_read      <= 1'b0;
      r_write     <= 1'b0;
      r_rdata     <= '0;
      r_resp_data <= 1'b0;
    end else begin
      case (r_state)
        c_idle: begin
          if (w_i_req || w_d_req) begin
            r_resp_data <= w_grant_d;
            if (w_grant_d) begin
              // A simultaneous read+write request is carried out as a write.
              r_addr  <= data_mem_address;
              r_read  <= ~data_write;
              r_write <= data_write;
              r_wdata <= data_write ? data_mem_wdata : '0;
              r_mbe   <= data_write ? data_mbe : 4'hF;
              r_state <= c_serve_d;
            end else begin
              r_addr  <= instr_mem_address;
              r_read  <= 1'b1;
              r_write <= 1'b0;
              r_wdata <= '0;
              r_mbe   <= 4'hF;
              r_state <= c_serve_i;
            end
          end
        end
        c_serve_i, c_serve_d: begin
          if (mem_resp) begin
            r_rdata <= mem_rdata;
            r_state <= c_resp;
          end
        end
        c_resp: begin
          r_state <= c_idle;
        end
        default: begin
          r_state <= c_idle;
        end
      endcase
    end
  end

  assign mem_read    = w_serving & r_read;
  assign mem_write   = w_serving & r_write;
  assign mem_address = w_serving ? r_addr  : '0;
  assign mem_wdata   = w_serving ? r_wdata : '0;
  assign mem_mbe     = w_serving ? r_mbe   : 4'h0;

  assign instr_mem_resp  = w_in_resp & ~r_resp_data;
  assign data_mem_resp   = w_in_resp &  r_resp_data;
  assign instr_mem_rdata = instr_mem_resp ? r_rdata : '0;
  assign data_mem_rdata  = data_mem_resp  ? r_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Self-checking bench for mem_arbiter (vectors, corner cases, random).
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;

  localparam int WIDTH = 32;
`ifdef ARB_RR_EN
  localparam bit c_rr = 1'b1;
`else
  localparam bit c_rr = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             instr_read;
  logic [WIDTH-1:0] instr_mem_address;
  logic             instr_mem_resp;
  logic [WIDTH-1:0] instr_mem_rdata;
  logic             data_read;
  logic             data_write;
  logic [3:0]       data_mbe;
  logic [WIDTH-1:0] data_mem_address;
  logic [WIDTH-1:0] data_mem_wdata;
  logic             data_mem_resp;
  logic [WIDTH-1:0] data_mem_rdata;
  logic             mem_read;
  logic             mem_write;
  logic [WIDTH-1:0] mem_address;
  logic [WIDTH-1:0] mem_wdata;
  logic [3:0]       mem_mbe;
  logic             mem_resp;
  logic [WIDTH-1:0] mem_rdata;

  mem_arbiter #(.WIDTH(WIDTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .instr_read        (instr_read),
    .instr_mem_address (instr_mem_address),
    .instr_mem_resp    (instr_mem_resp),
    .instr_mem_rdata   (instr_mem_rdata),
    .data_read         (data_read),
    .data_write        (data_write),
    .data_mbe          (data_mbe),
    .data_mem_address  (data_mem_address),
    .data_mem_wdata    (data_mem_wdata),
    .data_mem_resp     (data_mem_resp),
    .data_mem_rdata    (data_mem_rdata),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .mem_address       (mem_address),
    .mem_wdata         (mem_wdata),
    .mem_mbe           (mem_mbe),
    .mem_resp          (mem_resp),
    .mem_rdata         (mem_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: what each port has outstanding and who was granted last.
  bit          i_pend;
  bit          d_pend;
  bit          last_data;
  bit          m_dwr;
  logic [31:0] m_ia;
  logic [31:0] m_da;
  logic [31:0] m_dwd;
  logic [3:0]  m_mbe;

  typedef struct {
    bit          ir;
    bit          dr;
    bit          dw;
    logic [31:0] ia;
    logic [31:0] da;
    logic [31:0] dwd;
    logic [3:0]  mbe;
    logic [31:0] rdata;
    int          waits;
    bit          e_data;
    bit          e_rd;
    bit          e_wr;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_mbe;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, ".ctl"}, {mem_read, mem_write, instr_mem_resp, data_mem_resp}, 4'b0000);
    chk({tag, ".rdata0"}, instr_mem_rdata | data_mem_rdata, 32'h0);
  endtask

  task automatic check_mem(input string tag, input bit e_rd, input bit e_wr,
                           input logic [31:0] e_addr, input logic [31:0] e_wdata,
                           input logic [3:0] e_mbe, input bit chkwd);
    chk({tag, ".req"}, {mem_read, mem_write, mem_address}, {e_rd, e_wr, e_addr});
    chk({tag, ".wd"}, {mem_mbe, (chkwd ? mem_wdata : 32'h0)}, {e_mbe, (chkwd ? e_wdata : 32'h0)});
    chk({tag, ".noresp"}, {instr_mem_resp, data_mem_resp, instr_mem_rdata | data_mem_rdata}, 34'h0);
  endtask

  function automatic bit pick_data();
    if (i_pend && d_pend) return c_rr ? !last_data : 1'b1;
    return d_pend;
  endfunction

  task automatic exp_of(input bit is_data, output bit rd, output bit wr, output logic [31:0] a,
                        output logic [31:0] wd, output logic [3:0] mb, output bit cw);
    if (!is_data) begin
      rd = 1'b1; wr = 1'b0; a = m_ia; wd = 32'h0; mb = 4'hF; cw = 1'b1;
    end else begin
      wr = m_dwr; rd = !m_dwr; a = m_da; wd = m_dwd;
      mb = m_dwr ? m_mbe : 4'hF;
      cw = m_dwr;
    end
  endtask

  task automatic raise_i(input logic [31:0] a);
    i_pend = 1'b1; m_ia = a;
    instr_read = 1'b1; instr_mem_address = a;
  endtask

  task automatic raise_d(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] mb);
    d_pend = 1'b1; m_dwr = wr; m_da = a; m_dwd = wd; m_mbe = mb;
    data_read = rd; data_write = wr;
    data_mem_address = a; data_mem_wdata = wd; data_mbe = mb;
  endtask

  // Entered at a negedge of an IDLE cycle with requests already driven;
  // returns at the negedge of the core-response cycle.
  task automatic grant(input string tag, input bit e_data, input bit e_rd, input bit e_wr,
                       input logic [31:0] e_addr, input logic [31:0] e_wdata,
                       input logic [3:0] e_mbe, input bit chkwd, input logic [31:0] rdata,
                       input int waits, input bit wiggle);
    @(negedge clk);
    mem_resp = 1'b0;
    check_mem(tag, e_rd, e_wr, e_addr, e_wdata, e_mbe, chkwd);
    for (int w = 0; w < waits; w++) begin
      if (wiggle) begin
        if (e_data) begin
          data_mem_address ^= 32'h100;
          data_mem_wdata    = ~data_mem_wdata;
          data_mbe          = ~data_mbe;
        end else begin
          instr_mem_address ^= 32'h100;
        end
      end
      @(negedge clk);
      check_mem({tag, ".hold"}, e_rd, e_wr, e_addr, e_wdata, e_mbe, chkwd);
    end
    mem_rdata = rdata;
    mem_resp  = 1'b1;
    @(negedge clk);
    mem_resp  = 1'b0;
    mem_rdata = ~rdata;
    chk({tag, ".resp"}, {instr_mem_resp, data_mem_resp}, e_data ? 2'b01 : 2'b10);
    chk({tag, ".rdata"}, e_data ? data_mem_rdata : instr_mem_rdata, rdata);
    chk({tag, ".other"}, e_data ? instr_mem_rdata : data_mem_rdata, 32'h0);
    chk({tag, ".memoff"}, {mem_read, mem_write}, 2'b00);
    last_data = e_data;
    if (e_data) begin
      d_pend = 1'b0; data_read = 1'b0; data_write = 1'b0;
    end else begin
      i_pend = 1'b0; instr_read = 1'b0;
    end
  endtask

  task automatic serve_next(input string tag, input int waits, input bit wiggle);
    bit w, rd, wr, cw;
    logic [31:0] a, wd;
    logic [3:0]  mb;
    w = pick_data();
    exp_of(w, rd, wr, a, wd, mb, cw);
    grant(tag, w, rd, wr, a, wd, mb, cw, $urandom, waits, wiggle);
  endtask

  task automatic idle_step(input string tag, input bit noise);
    mem_resp  = noise;
    mem_rdata = $urandom;
    @(negedge clk);
    check_quiet(tag);
  endtask

  initial begin
    logic [2:0]  exp_order;
    logic [1:0]  op;
    bit          w, rd, wr, cw;
    logic [31:0] a, wd;
    logic [3:0]  mb;

    //          ir dr dw ia        da        dwd           mbe   rdata         wt  ed er ew e_addr    e_wdata       e_mbe
    tbl[0] = '{1, 0, 0, 32'h60,  32'h0,   32'h0,        4'h0, 32'h00000013, 3,  0, 1, 0, 32'h60,  32'h0,        4'hF};
    tbl[1] = '{0, 0, 1, 32'h0,   32'h104, 32'hAABB0000, 4'hC, 32'h0,        1,  1, 0, 1, 32'h104, 32'hAABB0000, 4'hC};
    tbl[2] = '{0, 1, 0, 32'h0,   32'h280, 32'h55,       4'h3, 32'hDEADBEEF, 0,  1, 1, 0, 32'h280, 32'h0,        4'hF};
    tbl[3] = '{1, 0, 0, 32'h64,  32'h0,   32'h0,        4'h0, 32'h00100093, 2,  0, 1, 0, 32'h64,  32'h0,        4'hF};
    tbl[4] = '{1, 1, 0, 32'h60,  32'h200, 32'h0,        4'h0, 32'h12345678, 1,  1, 1, 0, 32'h200, 32'h0,        4'hF};
    tbl[5] = '{1, 1, 1, 32'h68,  32'h204, 32'h11223344, 4'h5, 32'hA5A5A5A5, 0,  1, 0, 1, 32'h204, 32'h11223344, 4'h5};
    tbl[6] = '{0, 1, 1, 32'h0,   32'h300, 32'hCAFEF00D, 4'hF, 32'h0BADF00D, 2,  1, 0, 1, 32'h300, 32'hCAFEF00D, 4'hF};
    tbl[7] = '{1, 0, 0, 32'h70,  32'h0,   32'h0,        4'h0, 32'hFFFFFFFF, 0,  0, 1, 0, 32'h70,  32'h0,        4'hF};

    rst = 1'b1;
    instr_read = 1'b1; instr_mem_address = 32'h60;
    data_read = 1'b0; data_write = 1'b0; data_mbe = 4'h0;
    data_mem_address = 32'h0; data_mem_wdata = 32'h0;
    mem_resp = 1'b1; mem_rdata = 32'h1234;
    i_pend = 1'b0; d_pend = 1'b0; last_data = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset.ctl", {mem_read, mem_write, instr_mem_resp, data_mem_resp, mem_mbe}, 8'h0);
    chk("reset.data", mem_address | mem_wdata | instr_mem_rdata | data_mem_rdata, 32'h0);
    instr_read = 1'b0;
    rst = 1'b0;

    // mem_resp with no transaction in flight must be ignored
    idle_step("spurious0", 1'b1);
    idle_step("spurious1", 1'b1);

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].ir) raise_i(tbl[i].ia);
      if (tbl[i].dr || tbl[i].dw) raise_d(tbl[i].dr, tbl[i].dw, tbl[i].da, tbl[i].dwd, tbl[i].mbe);
      grant($sformatf("vec%0d", i), tbl[i].e_data, tbl[i].e_rd, tbl[i].e_wr, tbl[i].e_addr,
            tbl[i].e_wdata, tbl[i].e_mbe, tbl[i].e_wr | !tbl[i].e_data, tbl[i].rdata,
            tbl[i].waits, 1'b0);
      idle_step($sformatf("vec%0d.idle", i), 1'b0);
      if (i_pend || d_pend) begin
        serve_next($sformatf("vec%0d.loser", i), 1, 1'b0);
        idle_step($sformatf("vec%0d.loser.idle", i), 1'b0);
      end
    end

    // core moves its address while the load is in service
    raise_d(1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
    grant("hold_d", 1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 4'hF, 1'b0, 32'hFEED0001, 3, 1'b1);
    idle_step("hold_d.idle", 1'b1);

    // reset between clock edges while a fetch is in service
    raise_i(32'h60);
    @(negedge clk);
    chk("rst_mid.req", {mem_read, mem_address}, {1'b1, 32'h60});
    #2 rst = 1'b1;
    #1;
    chk("rst_mid.ctl", {mem_read, mem_write, instr_mem_resp, data_mem_resp, mem_mbe}, 8'h0);
    chk("rst_mid.data", mem_address | mem_wdata | instr_mem_rdata | data_mem_rdata, 32'h0);
    instr_read = 1'b0; i_pend = 1'b0; last_data = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mem_resp = 1'b1; mem_rdata = 32'h13;
    @(negedge clk);
    check_quiet("rst_mid.late0");
    @(negedge clk);
    check_quiet("rst_mid.late1");
    mem_resp = 1'b0;

    // back-to-back conflicts, winner re-requests every time
    exp_order = c_rr ? 3'b101 : 3'b111;
    raise_i(32'h60);
    raise_d(1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
    for (int n = 0; n < 3; n++) begin
      w = exp_order[n];
      exp_of(w, rd, wr, a, wd, mb, cw);
      grant($sformatf("b2b%0d", n), w, rd, wr, a, wd, mb, cw, $urandom, 1, 1'b0);
      if (w) raise_d(1'b1, 1'b0, 32'h200 + 32'(4 * (n + 1)), 32'h0, 4'h0);
      else   raise_i(32'h60 + 32'(4 * (n + 1)));
      idle_step($sformatf("b2b%0d.idle", n), 1'b0);
    end

    for (int it = 0; it < 300; it++) begin
      if (!i_pend && $urandom_range(0, 2) != 0) raise_i($urandom);
      if (!d_pend && $urandom_range(0, 2) != 0) begin
        op = 2'($urandom_range(1, 3));
        raise_d(op[0], op[1], $urandom, $urandom, 4'($urandom));
      end
      if (!i_pend && !d_pend) begin
        idle_step("rnd.empty", 1'($urandom));
      end else begin
        mem_resp = 1'($urandom);
        serve_next("rnd", $urandom_range(0, 3), 1'($urandom));
        idle_step("rnd.idle", 1'($urandom));
      end
    end

    for (int k = 0; k < 2 && (i_pend || d_pend); k++) begin
      serve_next("drain", 0, 1'b0);
      idle_step("drain.idle", 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
